pixel_frame_capture: RTL and testbench

Synthesizable receiving end of the two-pixel-per-clock RGB stream (VSYNC frame strobe, HSYNC pair qualifier, DATA_R0/G0/B0 and DATA_R1/G1/B1). It buffers incoming pixel pairs in a small FIFO and serialises them to one 24-bit pixel per clock. Each pixel goes out on a frame-memory write port, with the address flipped bottom-up to BMP row order. It replaces the file-writing sink in hardware builds and flags the frame boundary and any lost data.

---
 rtl/pixel_frame_capture.sv | 187 ++++++++++++++++++
 tb/tb_pixel_frame_capture.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_capture.sv
// pixel_frame_capture
//
// Receiving end of a two-pixel-per-clock RGB stream. Incoming pixel pairs
// are buffered in a small FIFO and serialised to one 24-bit pixel per clock
// on a frame-memory write port. Rows are stored bottom-up (BMP order).
//
// Ports:
//   HCLK        clock, all logic on the rising edge
//   HRESET      synchronous reset, active-high
//   VSYNC       frame start strobe (also restarts a frame in progress)
//   HSYNC       pixel pair valid this cycle
//   DATA_R0/G0/B0  pixel 0 of the pair (even column)
//   DATA_R1/G1/B1  pixel 1 of the pair (odd column)
//   WR_EN       memory write strobe
//   WR_ADDR     pixel address, WIDTH*(HEIGHT-1-row) + col
//   WR_DATA     {R,G,B}
//   FRAME_DONE  one-cycle pulse the cycle after the last pixel write
//   OVERFLOW    sticky, a pair was dropped on a full FIFO
//   BUSY        high while capturing a frame
module pixel_frame_capture #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              VSYNC,
    input  logic              HSYNC,
    input  logic [7:0]        DATA_R0,
    input  logic [7:0]        DATA_G0,
    input  logic [7:0]        DATA_B0,
    input  logic [7:0]        DATA_R1,
    input  logic [7:0]        DATA_G1,
    input  logic [7:0]        DATA_B1,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [23:0]       WR_DATA,
    output logic              FRAME_DONE,
    output logic              OVERFLOW,
    output logic              BUSY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = $clog2(WIDTH);

    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(WIDTH * (HEIGHT - 1));
    localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(WIDTH);
    localparam logic [COL_W-1:0]  COL_MAX       = COL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [47:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              half;
    logic              finish;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row_base;

    logic [47:0] in_pair;
    logic [47:0] head_pair;
    logic        active;
    logic        emit;
    logic        pop;
    logic        last_pixel;
    logic        push_req;
    logic        push_ok;
    logic        push_drop;

    assign in_pair   = {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
    assign head_pair = fifo_mem[rd_ptr];

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // VSYNC restarts from any state; the cycle after the last pixel
    // (finish) closes the frame.
    always_comb begin
        state_next = state;
        if (VSYNC) begin
            state_next = CAPTURE;
        end else if (state == CAPTURE && finish) begin
            state_next = DONE;
        end
    end

    // Per-edge datapath decisions. A pair may enter a full FIFO only when
    // the head retires on the same edge. Pairs arriving on the edge of the
    // final pixel are discarded silently along with the FIFO contents.
    always_comb begin
        active     = (state == CAPTURE) && !VSYNC && !finish;
        emit       = active && (count != '0);
        pop        = emit && half;
        last_pixel = emit && (row_base == '0) && (col == COL_MAX);
        push_req   = active && HSYNC && !last_pixel;
        push_ok    = push_req && ((count < DEPTH_CNT) || pop);
        push_drop  = push_req && !push_ok;
    end

    // FIFO storage; stale entries are harmless because pointers are reset.
    always_ff @(posedge HCLK) begin
        if (!HRESET && push_ok) begin
            fifo_mem[wr_ptr] <= in_pair;
        end
    end

    // Output registers, FIFO pointers and row/column tracking. The row is
    // kept as its bottom-up base address so no multiplier is needed.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            WR_EN      <= 1'b0;
            WR_ADDR    <= '0;
            WR_DATA    <= '0;
            FRAME_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
            BUSY       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            half       <= 1'b0;
            finish     <= 1'b0;
            col        <= '0;
            row_base   <= LAST_ROW_BASE;
        end else begin
            WR_EN      <= emit;
            FRAME_DONE <= (state == CAPTURE) && !VSYNC && finish;
            BUSY       <= (state_next == CAPTURE);
            if (emit) begin
                WR_ADDR <= row_base + ADDR_W'(col);
                WR_DATA <= half ? head_pair[23:0] : head_pair[47:24];
            end
            if (VSYNC || last_pixel) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                half     <= 1'b0;
                col      <= '0;
                row_base <= LAST_ROW_BASE;
                finish   <= last_pixel;
                if (VSYNC) begin
                    OVERFLOW <= 1'b0;
                end
            end else begin
                finish <= 1'b0;
                if (emit) begin
                    half <= ~half;
                    if (col == COL_MAX) begin
                        col      <= '0;
                        row_base <= row_base - ROW_STEP;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (push_drop) begin
                    OVERFLOW <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_capture.sv
// tb_pixel_frame_capture
//
// Drives two instances of pixel_frame_capture (a 4x2 frame and a 32x1
// frame, both with a 4-pair FIFO) from one clock and compares every output
// after every edge against a pixel-queue reference model.
module tb_pixel_frame_capture;

    logic        clk;
    logic        rst [2];
    logic        vs  [2];
    logic        hs  [2];
    logic [47:0] pr  [2];
    logic        wen [2];
    logic [18:0] wad [2];
    logic [23:0] wdt [2];
    logic        fdn [2];
    logic        ovf [2];
    logic        bsy [2];

    int n_pass;
    int n_total;

    // Reference model state, one slot per instance.
    int          mw [2];
    int          mh [2];
    int          md [2];
    int          mstate [2];
    int          mnpix [2];
    bit          mpend [2];
    logic [23:0] mq [2][$];
    logic        e_en [2];
    logic [18:0] e_addr [2];
    logic [23:0] e_data [2];
    logic        e_done [2];
    logic        e_ovf [2];
    logic        e_busy [2];

    // Observed write log {addr, data} and FRAME_DONE pulse counts.
    logic [42:0] wlog [2][$];
    int          dcount [2];
    int          exp_addr [8];

    pixel_frame_capture #(
        .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .ADDR_W(19)
    ) dut_small (
        .HCLK(clk), .HRESET(rst[0]), .VSYNC(vs[0]), .HSYNC(hs[0]),
        .DATA_R0(pr[0][47:40]), .DATA_G0(pr[0][39:32]), .DATA_B0(pr[0][31:24]),
        .DATA_R1(pr[0][23:16]), .DATA_G1(pr[0][15:8]),  .DATA_B1(pr[0][7:0]),
        .WR_EN(wen[0]), .WR_ADDR(wad[0]), .WR_DATA(wdt[0]),
        .FRAME_DONE(fdn[0]), .OVERFLOW(ovf[0]), .BUSY(bsy[0])
    );

    pixel_frame_capture #(
        .WIDTH(32), .HEIGHT(1), .FIFO_DEPTH(4), .ADDR_W(19)
    ) dut_wide (
        .HCLK(clk), .HRESET(rst[1]), .VSYNC(vs[1]), .HSYNC(hs[1]),
        .DATA_R0(pr[1][47:40]), .DATA_G0(pr[1][39:32]), .DATA_B0(pr[1][31:24]),
        .DATA_R1(pr[1][23:16]), .DATA_G1(pr[1][15:8]),  .DATA_B1(pr[1][7:0]),
        .WR_EN(wen[1]), .WR_ADDR(wad[1]), .WR_DATA(wdt[1]),
        .FRAME_DONE(fdn[1]), .OVERFLOW(ovf[1]), .BUSY(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int i,
                             input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
    endtask

    // Model of one edge: pixels wait in a queue in arrival order, one
    // leaves per cycle. Occupancy in pairs is ceil(pixels/2); a pair is
    // accepted if that is below the depth or a pair retires this edge
    // (odd pixel count means pixel 1 of the head goes out now).
    task automatic model_step(input int i);
        if (rst[i]) begin
            mstate[i] = 0;
            mq[i].delete();
            mnpix[i]  = 0;
            mpend[i]  = 1'b0;
            e_en[i]   = 1'b0;
            e_addr[i] = '0;
            e_data[i] = '0;
            e_done[i] = 1'b0;
            e_ovf[i]  = 1'b0;
            e_busy[i] = 1'b0;
        end else begin
            e_en[i]   = 1'b0;
            e_done[i] = 1'b0;
            if (vs[i]) begin
                mstate[i] = 1;
                mq[i].delete();
                mnpix[i]  = 0;
                mpend[i]  = 1'b0;
                e_ovf[i]  = 1'b0;
            end else if (mstate[i] == 1) begin
                if (mpend[i]) begin
                    e_done[i] = 1'b1;
                    mstate[i] = 2;
                    mpend[i]  = 1'b0;
                end else begin
                    int p0;
                    p0 = mq[i].size();
                    if (p0 > 0) begin
                        e_data[i] = mq[i].pop_front();
                        e_addr[i] = 19'(mw[i] * (mh[i] - 1 - mnpix[i] / mw[i]) + mnpix[i] % mw[i]);
                        e_en[i]   = 1'b1;
                        mnpix[i]++;
                    end
                    if (mnpix[i] == mw[i] * mh[i]) begin
                        mq[i].delete();
                        mpend[i] = 1'b1;
                    end else if (hs[i]) begin
                        if (((p0 + 1) / 2 < md[i]) || (p0 % 2 == 1)) begin
                            mq[i].push_back(pr[i][47:24]);
                            mq[i].push_back(pr[i][23:0]);
                        end else begin
                            e_ovf[i] = 1'b1;
                        end
                    end
                end
            end
            e_busy[i] = (mstate[i] == 1);
        end
    endtask

    task automatic check_output(input int i);
        check_val("wr_en",      i, 64'(wen[i]), 64'(e_en[i]));
        check_val("wr_addr",    i, 64'(wad[i]), 64'(e_addr[i]));
        check_val("wr_data",    i, 64'(wdt[i]), 64'(e_data[i]));
        check_val("frame_done", i, 64'(fdn[i]), 64'(e_done[i]));
        check_val("overflow",   i, 64'(ovf[i]), 64'(e_ovf[i]));
        check_val("busy",       i, 64'(bsy[i]), 64'(e_busy[i]));
        if (wen[i] === 1'b1) wlog[i].push_back({wad[i], wdt[i]});
        if (fdn[i] === 1'b1) dcount[i]++;
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) check_output(i);
    endtask

    task automatic apply_stimulus(input int i, input logic r, input logic v,
                                  input logic h, input logic [47:0] p);
        rst[i] = r;
        vs[i]  = v;
        hs[i]  = h;
        pr[i]  = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 2; i++) apply_stimulus(i, 1'b0, 1'b0, 1'b0, pr[i]);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic vsync_pulse(input int i);
        apply_stimulus(i, 1'b0, 1'b1, 1'b0, pr[i]);
        step();
        apply_stimulus(i, 1'b0, 1'b0, 1'b0, pr[i]);
    endtask

    task automatic send_pair(input int i, input logic [47:0] p);
        apply_stimulus(i, 1'b0, 1'b0, 1'b1, p);
        step();
        apply_stimulus(i, 1'b0, 1'b0, 1'b0, p);
    endtask

    function automatic logic [47:0] rand_pair();
        return {24'($urandom), 24'($urandom)};
    endfunction

    task automatic clear_log(input int i);
        wlog[i].delete();
        dcount[i] = 0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        mw[0] = 4;  mh[0] = 2; md[0] = 4;
        mw[1] = 32; mh[1] = 1; md[1] = 4;
        exp_addr = '{4, 5, 6, 7, 0, 1, 2, 3};
        for (int i = 0; i < 2; i++) begin
            mstate[i] = 0; mnpix[i] = 0; mpend[i] = 1'b0;
            e_en[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
            e_done[i] = 1'b0; e_ovf[i] = 1'b0; e_busy[i] = 1'b0;
            dcount[i] = 0;
            apply_stimulus(i, 1'b1, 1'b0, 1'b0, '0);
        end

        $display("[TB] reset with random inputs");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++)
                apply_stimulus(i, 1'b1, 1'($urandom), 1'($urandom), rand_pair());
            step();
        end

        $display("[TB] HSYNC while idle");
        for (int i = 0; i < 2; i++) clear_log(i);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) apply_stimulus(i, 1'b0, 1'b0, 1'b1, rand_pair());
            step();
        end
        idle(2);
        check_val("idle_no_writes", 0, 64'(wlog[0].size()), 64'd0);
        check_val("idle_no_writes", 1, 64'(wlog[1].size()), 64'd0);

        $display("[TB] nominal 4x2 frame");
        clear_log(0);
        vsync_pulse(0);
        for (int row = 0; row < 2; row++) begin
            for (int p = 0; p < 2; p++) begin
                int idx;
                idx = row * 4 + p * 2;
                send_pair(0, {24'(idx), 24'(idx + 1)});
            end
            idle(4);
        end
        idle(6);
        check_val("nominal_writes", 0, 64'(wlog[0].size()), 64'd8);
        for (int k = 0; k < 8 && k < wlog[0].size(); k++) begin
            check_val("nominal_addr", 0, 64'(wlog[0][k][42:24]), 64'(exp_addr[k]));
            check_val("nominal_data", 0, 64'(wlog[0][k][23:0]), 64'(k));
        end
        check_val("nominal_done_count", 0, 64'(dcount[0]), 64'd1);
        check_val("nominal_overflow", 0, 64'(ovf[0]), 64'd0);

        $display("[TB] overflow on 32x1 frame");
        clear_log(1);
        vsync_pulse(1);
        for (int k = 0; k < 12; k++) send_pair(1, rand_pair());
        idle(40);
        check_val("ovf_set", 1, 64'(ovf[1]), 64'd1);
        check_val("ovf_writes_lt24", 1, 64'(wlog[1].size() < 24), 64'd1);
        for (int k = 0; k < wlog[1].size(); k++)
            check_val("ovf_addr_contig", 1, 64'(wlog[1][k][42:24]), 64'(k));
        check_val("ovf_no_done", 1, 64'(dcount[1]), 64'd0);
        vsync_pulse(1);
        idle(1);
        check_val("ovf_cleared", 1, 64'(ovf[1]), 64'd0);
        idle(1);

        $display("[TB] restart after 3 pixels");
        clear_log(0);
        vsync_pulse(0);
        send_pair(0, rand_pair());
        send_pair(0, rand_pair());
        for (int t = 0; t < 20 && wlog[0].size() < 3; t++) step();
        check_val("restart_three_written", 0, 64'(wlog[0].size() >= 3), 64'd1);
        vsync_pulse(0);
        check_val("restart_no_done", 0, 64'(dcount[0]), 64'd0);
        clear_log(0);
        for (int row = 0; row < 2; row++) begin
            send_pair(0, rand_pair());
            send_pair(0, rand_pair());
            idle(4);
        end
        idle(6);
        check_val("restart_writes", 0, 64'(wlog[0].size()), 64'd8);
        if (wlog[0].size() > 0)
            check_val("restart_first_addr", 0, 64'(wlog[0][0][42:24]), 64'd4);
        check_val("restart_done_count", 0, 64'(dcount[0]), 64'd1);

        $display("[TB] HSYNC with VSYNC on the same edge");
        begin
            logic [47:0] pa, pb;
            pa = 48'hAAAAAA_BBBBBB;
            pb = rand_pair();
            clear_log(0);
            apply_stimulus(0, 1'b0, 1'b1, 1'b1, pa);
            step();
            send_pair(0, pb);
            idle(3);
            send_pair(0, rand_pair());
            idle(4);
            send_pair(0, rand_pair());
            send_pair(0, rand_pair());
            idle(6);
            check_val("same_edge_writes", 0, 64'(wlog[0].size()), 64'd8);
            if (wlog[0].size() > 0)
                check_val("same_edge_first_data", 0, 64'(wlog[0][0][23:0]), 64'(pb[47:24]));
            check_val("same_edge_done_count", 0, 64'(dcount[0]), 64'd1);
        end

        $display("[TB] reset mid-frame");
        clear_log(1);
        vsync_pulse(1);
        for (int t = 0; t < 20 && wlog[1].size() < 5; t++) begin
            send_pair(1, rand_pair());
            idle(1);
        end
        check_val("midreset_five_written", 1, 64'(wlog[1].size() >= 5), 64'd1);
        apply_stimulus(1, 1'b1, 1'b0, 1'b0, pr[1]);
        step();
        apply_stimulus(1, 1'b0, 1'b0, 1'b0, pr[1]);
        check_val("midreset_wr_en", 1, 64'(wen[1]), 64'd0);
        check_val("midreset_busy", 1, 64'(bsy[1]), 64'd0);
        check_val("midreset_no_done", 1, 64'(dcount[1]), 64'd0);
        clear_log(1);
        vsync_pulse(1);
        for (int k = 0; k < 16; k++) begin
            send_pair(1, rand_pair());
            idle(1);
        end
        idle(8);
        check_val("after_reset_writes", 1, 64'(wlog[1].size()), 64'd32);
        if (wlog[1].size() == 32)
            check_val("after_reset_last_addr", 1, 64'(wlog[1][31][42:24]), 64'd31);
        check_val("after_reset_done_count", 1, 64'(dcount[1]), 64'd1);
        check_val("after_reset_overflow", 1, 64'(ovf[1]), 64'd0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++)
                apply_stimulus(i, ($urandom_range(199) == 0), ($urandom_range(39) == 0),
                               ($urandom_range(2) != 0), rand_pair());
            step();
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
